mod_harmonic_sequencer: RTL

MOD_HARMONIC_SEQUENCER -- requirements
Module: mod_harmonic_sequencer

---
 rtl/mod_synth_pkg.sv | 14 +
 rtl/mod_sat_reduce.sv | 28 ++
 rtl/mod_harmonic_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mod_synth_pkg.sv
// Shared types and widths for the harmonic sequencer: FSM state encoding
// and the sample/time/fixed-point widths used on every port.
package mod_synth_pkg;
   localparam int SAMPLE_W = 32;
   localparam int TIME_W   = 64;
   localparam int FIX_FRAC = 14;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/mod_sat_reduce.sv
// Reduces the wide harmonic accumulator to one 32-bit sample. Wraps by default;
// saturates to the signed 32-bit range when MOD_HARMSEQ_SAT_EN is defined.
module mod_sat_reduce
   import mod_synth_pkg::*;
#(
   parameter int IN_W = 35
) (
   input  logic signed [IN_W-1:0]     din,
   output logic signed [SAMPLE_W-1:0] dout
);
`ifdef MOD_HARMSEQ_SAT_EN
   // In range only when every bit from the 32-bit sign position upward agrees.
   logic [IN_W-SAMPLE_W:0] top;
   assign top = din[IN_W-1:SAMPLE_W-1];

   always_comb begin
      dout = din[SAMPLE_W-1:0];
      if (!(&top || ~|top)) begin
         if (din[IN_W-1]) dout = {1'b1, {(SAMPLE_W-1){1'b0}}};
         else             dout = {1'b0, {(SAMPLE_W-1){1'b1}}};
      end
   end
`else
   logic unused_hi;
   assign unused_hi = ^din[IN_W-1:SAMPLE_W-1];
   assign dout      = din[SAMPLE_W-1:0];
`endif
endmodule

// File: rtl/mod_harmonic_sequencer.sv
// Sequences the enabled harmonics of one sample through a shared sine+attenuator
// source and sums the results. Optional saturation: MOD_HARMSEQ_SAT_EN.
module mod_harmonic_sequencer
   import mod_synth_pkg::*;
#(
   parameter int NUM_HARMONICS  = 5,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       i_clk,
   input  logic                       i_nrst,
   input  logic                       i_trigger,
   input  logic [TIME_W-1:0]          i_time,
   input  logic [31:0]                i_frequency,
   input  logic [31:0]                i_atten_harmonics [0:NUM_HARMONICS-1],
   input  logic [NUM_HARMONICS-1:0]   i_harmonic_en,
   output logic                       o_src_trigger,
   output logic [TIME_W-1:0]          o_src_time,
   output logic [31:0]                o_src_frequency,
   output logic [31:0]                o_src_atten,
   input  logic signed [SAMPLE_W-1:0] i_src_sample,
   input  logic                       i_src_ready,
   output logic signed [SAMPLE_W-1:0] o_sound,
   output logic                       o_ready,
   output logic                       o_busy,
   output logic                       o_overrun,
   output logic                       o_timeout,
   output state_t                     o_state
);
   localparam int HW    = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
   localparam int ACC_W = SAMPLE_W + $clog2(NUM_HARMONICS);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   // Source handshake: o_src_trigger is a one-cycle start while the src_* operands
   // are held; i_src_ready is a one-cycle result-valid pulse, honoured only in WAIT.
   state_t                   state;
   logic [HW-1:0]            cur_h;
   logic [CNT_W-1:0]         wait_cnt;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  sample_ext;
   logic signed [SAMPLE_W-1:0] reduced;
   logic                     nxt_found;
   logic [HW-1:0]            nxt_h;

   assign sample_ext = ACC_W'(i_src_sample);
   assign o_busy     = (state != ST_IDLE);
   assign o_state    = state;

   // Lowest enabled harmonic above the current one, using the live mask.
   always_comb begin
      nxt_found = 1'b0;
      nxt_h     = '0;
      for (int k = NUM_HARMONICS - 1; k >= 0; k--) begin
         if (i_harmonic_en[k] && (state == ST_IDLE || k > int'(cur_h))) begin
            nxt_found = 1'b1;
            nxt_h     = HW'(k);
         end
      end
   end

   mod_sat_reduce #(.IN_W(ACC_W)) u_reduce (
      .din  (acc),
      .dout (reduced)
   );

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state           <= ST_IDLE;
         cur_h           <= '0;
         wait_cnt        <= '0;
         acc             <= '0;
         o_src_trigger   <= 1'b0;
         o_src_time      <= '0;
         o_src_frequency <= '0;
         o_src_atten     <= '0;
         o_sound         <= '0;
         o_ready         <= 1'b0;
         o_overrun       <= 1'b0;
         o_timeout       <= 1'b0;
      end else begin
         o_src_trigger <= 1'b0;
         o_ready       <= 1'b0;
         o_timeout     <= 1'b0;
         o_overrun     <= i_trigger && (state != ST_IDLE);

         // The next operands are registered on entry to ISSUE so the start pulse
         // and its operands appear together during the ISSUE cycle.
         if ((state == ST_IDLE && i_trigger) ||
             (state == ST_WAIT && (i_src_ready || wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)))) begin
            if (nxt_found) begin
               state           <= ST_ISSUE;
               cur_h           <= nxt_h;
               o_src_trigger   <= 1'b1;
               o_src_frequency <= i_frequency << nxt_h;
               o_src_atten     <= i_atten_harmonics[nxt_h];
            end else begin
               state <= ST_DONE;
            end
         end

         case (state)
            ST_IDLE: begin
               if (i_trigger) begin
                  o_src_time <= i_time;
                  acc        <= '0;
               end
            end
            ST_ISSUE: begin
               state    <= ST_WAIT;
               wait_cnt <= '0;
            end
            ST_WAIT: begin
               if (i_src_ready)                                  acc <= acc + sample_ext;
               else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))  o_timeout <= 1'b1;
               else                                              wait_cnt <= wait_cnt + 1'b1;
            end
            ST_DONE: begin
               o_sound <= reduced;
               o_ready <= 1'b1;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
